// File: rtl/rvfi_serializer_pkg.sv
// Shared types for the RVFI retirement serializer: retire entry layout,
// event kinds and FSM states.
package rvfi_serializer_pkg;

  localparam int XLEN = 32;

  typedef struct packed {
    logic [63:0]     order;
    logic [XLEN-1:0] pc;
    logic [31:0]     insn;
    logic            trap;
    logic            intr;
    logic [31:0]     mip;
  } retire_entry_t;

  localparam int ENTRY_W   = $bits(retire_entry_t);
  // Field positions inside a flattened entry, for logic that only needs a few fields.
  localparam int ORDER_LSB = ENTRY_W - 64;
  localparam int INTR_BIT  = 32;

  typedef enum logic {
    EV_STEP = 1'b0,
    EV_INTR = 1'b1
  } ev_kind_e;

  typedef enum logic {
    S_STEP      = 1'b0,
    S_INTR_DONE = 1'b1
  } state_e;

endpackage

// File: rtl/rvfi_multi_push_fifo.sv
// In-order FIFO taking up to NRET compacted pushes per cycle and one pop.
// Occupancy resolves full/empty; the head is presented from storage with no added latency.
module rvfi_multi_push_fifo
  import rvfi_serializer_pkg::*;
#(
  parameter int NRET  = 2,
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          push,
  input  logic [NRET-1:0]               lane_valid,
  input  logic [NRET-1:0][ENTRY_W-1:0]  lane_entry,
  input  logic                          pop,
  output logic [ENTRY_W-1:0]            head,
  output logic                          empty,
  output logic [CNT_W-1:0]              occupancy
);

  logic [ENTRY_W-1:0]           mem [DEPTH];
  logic [PTR_W-1:0]             wr_ptr, rd_ptr;
  logic [CNT_W-1:0]             occ, occ_nxt;
  logic [CNT_W-1:0]             push_cnt;
  logic [NRET-1:0][PTR_W-1:0]   wr_idx;

  // Each valid lane lands at wr_ptr plus the number of valid lanes below it,
  // so gaps in the lane mask collapse into consecutive slots.
  always_comb begin
    push_cnt = '0;
    wr_idx   = '0;
    for (int i = 0; i < NRET; i++) begin
      wr_idx[i] = wr_ptr + push_cnt[PTR_W-1:0];
      push_cnt  = push_cnt + CNT_W'(lane_valid[i]);
    end
  end

  always_comb begin
    occ_nxt = occ;
    if (push) occ_nxt = occ_nxt + push_cnt;
    if (pop)  occ_nxt = occ_nxt - CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      occ <= occ_nxt;
      if (push) wr_ptr <= wr_ptr + push_cnt[PTR_W-1:0];
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NRET; i++)
      if (push && lane_valid[i]) mem[wr_idx[i]] <= lane_entry[i];
  end

  assign empty     = (occ == '0);
  assign occupancy = occ;
  assign head      = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/rvfi_retire_serializer.sv
// Buffers multi-lane RVFI retirements and issues them one event per handshake,
// splitting interrupt-tagged retirements into INTR then STEP, with order and overflow checks.
module rvfi_retire_serializer
  import rvfi_serializer_pkg::*;
#(
  parameter int NRET  = 2,
  parameter int DEPTH = 16,
  parameter int XLEN  = 32,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NRET-1:0]               in_valid_i,
  input  logic [NRET-1:0][ENTRY_W-1:0]  in_entry_i,
  output logic                          in_ready_o,
  output logic                          out_valid_o,
  output logic                          out_kind_o,
  output logic [ENTRY_W-1:0]            out_entry_o,
  input  logic                          out_ready_i,
  output logic [CNT_W-1:0]              occupancy_o,
  output logic                          order_err_o,
  output logic                          overflow_o
);

  if (XLEN != rvfi_serializer_pkg::XLEN) begin : g_bad_xlen
    $error("XLEN must match rvfi_serializer_pkg::XLEN");
  end
  if (NRET < 1 || NRET > 4 || DEPTH < 2 * NRET || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("unsupported NRET/DEPTH combination");
  end

  state_e             state, state_nxt;
  ev_kind_e           kind;
  logic               rdy_q;
  logic               push, pop, fire, empty;
  logic [ENTRY_W-1:0] head;
  logic [63:0]        head_order;
  logic               head_intr;
  logic [63:0]        exp_order;
  logic               order_err, overflow;

  // rdy_q keeps in_ready_o low while reset is held and for no longer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rdy_q <= 1'b0;
    else         rdy_q <= 1'b1;
  end

  assign in_ready_o = rdy_q && (occupancy_o <= CNT_W'(DEPTH - NRET));
  assign push       = in_ready_o && (|in_valid_i);

  rvfi_multi_push_fifo #(
    .NRET  (NRET),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push       (push),
    .lane_valid (in_valid_i),
    .lane_entry (in_entry_i),
    .pop        (pop),
    .head       (head),
    .empty      (empty),
    .occupancy  (occupancy_o)
  );

  assign head_order = head[ENTRY_W-1:ORDER_LSB];
  assign head_intr  = head[INTR_BIT];

  assign out_valid_o = !empty;
  assign out_entry_o = head;
  assign out_kind_o  = kind;
  assign fire        = out_valid_o && out_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= S_STEP;
    else         state <= state_nxt;
  end

  // The INTR half of a split retirement leaves the head in place; only STEP pops.
  always_comb begin
    state_nxt = state;
    kind      = EV_STEP;
    pop       = 1'b0;
    if (out_valid_o && state == S_STEP && head_intr) kind = EV_INTR;
    if (fire) begin
      if (kind == EV_INTR) begin
        state_nxt = S_INTR_DONE;
      end else begin
        pop       = 1'b1;
        state_nxt = S_STEP;
      end
    end
  end

  // Expected order always resyncs to the popped entry so one gap is flagged once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exp_order <= '0;
      order_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (pop) begin
        if (head_order != exp_order) order_err <= 1'b1;
        exp_order <= head_order + 64'd1;
      end
      if ((|in_valid_i) && !in_ready_o) overflow <= 1'b1;
    end
  end

  assign order_err_o = order_err;
  assign overflow_o  = overflow;

endmodule

// File: doc/rvfi_retire_serializer.md
Name: rvfi_retire_serializer

Overview:
- Sits directly upstream of the ISS step/interrupt wrapper in the CVA6 reference-model path.
- Captures up to NRET RVFI retirements per cycle from the core, buffers them in order, and issues them one event per handshake to the consumer that drives the ISS.
- Splits an interrupt-tagged retirement into an INTR event (carries mip, consumer applies it to the ISS) followed by a STEP event (consumer steps the ISS and compares).
- Checks retirement order continuity and flags overflow.

Parameters:
- NRET, 2, retire lanes per cycle (1..4)
- DEPTH, 16, FIFO entries; power of two, DEPTH >= 2*NRET
- XLEN, 32, PC width

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- in_valid_i  in  NRET  per-lane retirement valid
- in_entry_i  in  NRET x ENTRY_W  per-lane retire_entry_t {order[63:0], pc[XLEN-1:0], insn[31:0], trap, intr, mip[31:0]}
- in_ready_o  out  1  core may present retirements this cycle
- out_valid_o  out  1  event available
- out_kind_o  out  1  0=STEP, 1=INTR
- out_entry_o  out  ENTRY_W  head entry
- out_ready_i  in  1  consumer accepts event
- occupancy_o  out  $clog2(DEPTH)+1  entries held
- order_err_o  out  1  sticky: order discontinuity seen
- overflow_o  out  1  sticky: valid lanes presented while in_ready_o=0

Behaviour:
- Reset (async, rst_ni=0): FIFO empty, occupancy_o=0, out_valid_o=0, out_kind_o=0, out_entry_o=0, in_ready_o=0 while asserted and 1 from the first clock after release, order_err_o=0, overflow_o=0, expected order=0, FSM=S_STEP. Reset mid-transfer discards all content without draining.
- Acceptance: in_ready_o = (DEPTH - occupancy) >= NRET, computed from registered occupancy. A pop in the same cycle does not create push space. Acceptance is all-or-nothing per cycle.
- Compaction: valid lanes are written in ascending lane index. Gaps are allowed (e.g. lanes 0 and 2 only). Pushes k = popcount(in_valid_i) entries, and occupancy updates by +k-pop in one cycle.
- Overflow: any in_valid_i bit while in_ready_o=0 sets overflow_o (sticky). The data is dropped and the FIFO is untouched.
- Output: out_valid_o=1 iff FIFO is non-empty. out_entry_o is the head with zero added latency. The earliest presentation is the cycle after the push (registered FIFO).
- Handshake: an event transfers on out_valid_o && out_ready_i. While out_valid_o=1 and out_ready_i=0, out_kind_o and out_entry_o are held stable.
- FSM S_STEP / S_INTR:
  - On entering a new head with intr=1 and state S_STEP, the FSM moves combinationally into presenting an INTR event (out_kind_o=1). On its handshake the state becomes S_INTR_DONE and the head is not popped.
  - In S_INTR_DONE, out_kind_o=0. On handshake the head is popped and the state returns to S_STEP.
  - A head with intr=0 presents STEP directly and pops on handshake.
  - An entry with both trap=1 and intr=1 follows the intr path; the trap bit is forwarded untouched.
- Order check: on each STEP pop, if head.order != expected, order_err_o is set. In either case expected is set to head.order+1 (resynchronise). The 64-bit counter wraps modulo 2^64 without error.
- Pointers are $clog2(DEPTH) bits, wrapping naturally. Full vs empty is resolved by occupancy.

Decomposition:
- Package rvfi_serializer_pkg: retire_entry_t packed struct, ENTRY_W, event kind enum (EV_STEP=0, EV_INTR=1), FSM state enum.
- One sub-module: rvfi_multi_push_fifo (NRET-wide compacting push, single pop, occupancy). The top holds the FSM, order checker and sticky flags.

Test Plan:
- Reset, then push lane0 order=0, pc=0x80 -> next cycle out_valid_o=1, kind=0, pc=0x80. With out_ready_i=1 the entry pops, occupancy_o returns to 0, order_err_o=0.
- NRET=2, push both lanes (order 5,6) with out_ready_i=0 for 3 cycles -> occupancy_o=2, output stable at order 5. Release -> orders 5 then 6 on consecutive cycles.
- Head intr=1, mip=0x80 -> first event kind=1 with mip=0x80, occupancy unchanged. Second event kind=0, same order. Then pop.
- Fill to DEPTH-1 with NRET=2 -> in_ready_o=0. Drive valid -> overflow_o=1, occupancy stays 15, no entry corrupted.
- Orders 0,1,3 popped -> order_err_o rises on the pop of 3 and stays 1. A following order 4 raises no new discontinuity.
- Assert rst_ni=0 mid-stream with 7 entries held -> immediately occupancy_o=0, out_valid_o=0, flags cleared.
